// File: rtl/draw_scheduler_if.sv
// Rectangle request bus between the frame scheduler (master) and the rectangle drawer (slave).
interface draw_if;
   logic [7:0] start_x;
   logic [6:0] start_y;
   logic [3:0] width;
   logic [3:0] height;
   logic [2:0] color;
   logic       draw;
   logic       done;

   modport master (output start_x, start_y, width, height, color, draw, input done);
   modport slave  (input start_x, start_y, width, height, color, draw, output done);
endinterface

// File: rtl/draw_scheduler.sv
// Per-frame sprite scheduler: erases last frame's rectangles, then draws this frame's,
// one rectangle at a time through a draw/done handshake.
module draw_scheduler #(
   parameter logic [3:0] OBJ_W     = 4'd10,
   parameter logic [3:0] OBJ_H     = 4'd10,
   parameter logic [2:0] BG_COLOUR = 3'b000
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_frame_tick,
   input  logic [39:0] i_obj_x,
   input  logic [34:0] i_obj_y,
   input  logic [14:0] i_obj_c,
   input  logic [4:0]  i_obj_valid,
   draw_if.master      m_drw,
   output logic        o_busy,
   output logic        o_frame_done,
   output logic        o_overrun
);

   typedef enum logic [2:0] {
      IDLE, SNAP, ERASE_REQ, ERASE_WAIT, DRAW_REQ, DRAW_WAIT, FINISH
   } state_t;

   state_t          r_state;
   logic [2:0]      r_slot;
   logic [4:0][7:0] r_new_x, r_old_x;
   logic [4:0][6:0] r_new_y, r_old_y;
   logic [4:0][2:0] r_new_c;
   logic [4:0]      r_new_v, r_old_v;
   logic [7:0]      r_start_x;
   logic [6:0]      r_start_y;
   logic [2:0]      r_color;
   logic            r_draw, r_busy, r_frame_done, r_overrun;

   logic [4:0][7:0] w_obj_x;
   logic [4:0][6:0] w_obj_y;
   logic [4:0][2:0] w_obj_c;
   logic            w_last;

   assign w_obj_x = i_obj_x;
   assign w_obj_y = i_obj_y;
   assign w_obj_c = i_obj_c;
   assign w_last  = (r_slot == 3'd4);

   assign m_drw.start_x = r_start_x;
   assign m_drw.start_y = r_start_y;
   assign m_drw.width   = OBJ_W;
   assign m_drw.height  = OBJ_H;
   assign m_drw.color   = r_color;
   assign m_drw.draw    = r_draw;
   assign o_busy        = r_busy;
   assign o_frame_done  = r_frame_done;
   assign o_overrun     = r_overrun;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state      <= IDLE;
         r_slot       <= 3'd0;
         r_new_x      <= '0;
         r_new_y      <= '0;
         r_new_c      <= '0;
         r_new_v      <= '0;
         r_old_x      <= '0;
         r_old_y      <= '0;
         r_old_v      <= '0;
         r_start_x    <= '0;
         r_start_y    <= '0;
         r_color      <= '0;
         r_draw       <= 1'b0;
         r_busy       <= 1'b0;
         r_frame_done <= 1'b0;
         r_overrun    <= 1'b0;
      end else begin
         r_draw       <= 1'b0;
         r_frame_done <= 1'b0;
         // A tick is only accepted in a quiet IDLE; during the frame_done cycle it is dropped too.
         if (i_frame_tick && (r_state != IDLE || r_frame_done))
            r_overrun <= 1'b1;

         case (r_state)
            IDLE: begin
               if (i_frame_tick && !r_frame_done) begin
                  r_state <= SNAP;
                  r_busy  <= 1'b1;
               end
            end
            SNAP: begin
               r_new_x <= w_obj_x;
               r_new_y <= w_obj_y;
               r_new_c <= w_obj_c;
               r_new_v <= i_obj_valid;
               r_slot  <= 3'd0;
               r_state <= ERASE_REQ;
            end
            ERASE_REQ: begin
               if (r_old_v[r_slot]) begin
                  r_start_x <= r_old_x[r_slot];
                  r_start_y <= r_old_y[r_slot];
                  r_color   <= BG_COLOUR;
                  r_draw    <= 1'b1;
                  r_state   <= ERASE_WAIT;
               end else if (w_last) begin
                  r_slot  <= 3'd0;
                  r_state <= DRAW_REQ;
               end else begin
                  r_slot <= r_slot + 3'd1;
               end
            end
            ERASE_WAIT: begin
               if (m_drw.done) begin
                  if (w_last) begin
                     r_slot  <= 3'd0;
                     r_state <= DRAW_REQ;
                  end else begin
                     r_slot  <= r_slot + 3'd1;
                     r_state <= ERASE_REQ;
                  end
               end
            end
            DRAW_REQ: begin
               if (r_new_v[r_slot]) begin
                  r_start_x <= r_new_x[r_slot];
                  r_start_y <= r_new_y[r_slot];
                  r_color   <= r_new_c[r_slot];
                  r_draw    <= 1'b1;
                  r_state   <= DRAW_WAIT;
               end else if (w_last) begin
                  r_state <= FINISH;
               end else begin
                  r_slot <= r_slot + 3'd1;
               end
            end
            DRAW_WAIT: begin
               if (m_drw.done) begin
                  if (w_last) begin
                     r_state <= FINISH;
                  end else begin
                     r_slot  <= r_slot + 3'd1;
                     r_state <= DRAW_REQ;
                  end
               end
            end
            FINISH: begin
               r_old_x      <= r_new_x;
               r_old_y      <= r_new_y;
               r_old_v      <= r_new_v;
               r_slot       <= 3'd0;
               r_frame_done <= 1'b1;
               r_busy       <= 1'b0;
               r_state      <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_draw_scheduler.sv
// Directed bench for draw_scheduler with a behavioural drawer that answers each draw after lat cycles.
module tb_draw_scheduler;

   typedef struct packed {
      logic [7:0] x;
      logic [6:0] y;
      logic [2:0] c;
   } rect_t;

   logic        clk = 1'b0;
   logic        i_reset = 1'b1;
   logic        i_frame_tick = 1'b0;
   logic [39:0] obj_x = '0;
   logic [34:0] obj_y = '0;
   logic [14:0] obj_c = '0;
   logic [4:0]  obj_valid = '0;
   logic        o_busy, o_frame_done, o_overrun;

   int    tests = 0;
   int    fails = 0;
   int    lat = 3;
   int    cnt = 0;
   int    stab_err = 0;
   rect_t last_r;
   rect_t log_q[$];

   draw_if dif ();

   draw_scheduler dut (
      .i_clk        (clk),
      .i_reset      (i_reset),
      .i_frame_tick (i_frame_tick),
      .i_obj_x      (obj_x),
      .i_obj_y      (obj_y),
      .i_obj_c      (obj_c),
      .i_obj_valid  (obj_valid),
      .m_drw        (dif.master),
      .o_busy       (o_busy),
      .o_frame_done (o_frame_done),
      .o_overrun    (o_overrun)
   );

   always #5 clk = ~clk;

   // Drawer model: logs each request and checks the request stays put until done.
   initial begin
      dif.done = 1'b0;
      forever begin
         @(negedge clk);
         dif.done = 1'b0;
         if (dif.draw) begin
            last_r = {dif.start_x, dif.start_y, dif.color};
            log_q.push_back(last_r);
            cnt = lat;
         end else if (cnt > 0) begin
            if ({dif.start_x, dif.start_y, dif.color} !== last_r) stab_err++;
            cnt--;
            if (cnt == 0) dif.done = 1'b1;
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   function automatic rect_t mk(input int x, input int y, input int c);
      rect_t r;
      r.x = 8'(x);
      r.y = 7'(y);
      r.c = 3'(c);
      return r;
   endfunction

   task automatic set_obj(input int k, input int x, input int y, input int c);
      obj_x[8*k +: 8] = 8'(x);
      obj_y[7*k +: 7] = 7'(y);
      obj_c[3*k +: 3] = 3'(c);
   endtask

   task automatic do_reset();
      @(negedge clk);
      i_reset = 1'b1;
      repeat (2) @(negedge clk);
      i_reset = 1'b0;
      log_q.delete();
   endtask

   // Pulses frame_tick and waits for frame_done; returns at the negedge where frame_done is seen.
   task automatic run_frame(input int mid, output int cyc);
      @(negedge clk);
      i_frame_tick = 1'b1;
      @(negedge clk);
      i_frame_tick = 1'b0;
      cyc = 1;
      while (!o_frame_done && cyc < 3000) begin
         if (cyc == mid) begin
            i_frame_tick = 1'b1;
            obj_x = {5{8'd200}};
            obj_valid = 5'b0;
         end else begin
            i_frame_tick = 1'b0;
         end
         @(negedge clk);
         cyc++;
      end
      i_frame_tick = 1'b0;
      tests++;
      if (!o_frame_done) begin
         fails++;
         $display("FAIL frame_timeout: frame_done=%b after %0d cycles, required 1", o_frame_done, cyc);
      end
   endtask

   task automatic test_reset();
      do_reset();
      tests++;
      if ({dif.draw, o_busy, o_frame_done, o_overrun} !== 4'b0000) begin
         fails++;
         $display("FAIL reset_flags: draw/busy/fdone/ovr=%b required 0000",
                  {dif.draw, o_busy, o_frame_done, o_overrun});
      end
      tests++;
      if ({dif.start_x, dif.start_y, dif.color} !== 18'd0) begin
         fails++;
         $display("FAIL reset_rect: x=%0d y=%0d c=%0d required 0 0 0", dif.start_x, dif.start_y, dif.color);
      end
      tests++;
      if (dif.width !== 4'd10 || dif.height !== 4'd10) begin
         fails++;
         $display("FAIL reset_size: w=%0d h=%0d required 10 10", dif.width, dif.height);
      end
   endtask

   task automatic test_empty_frame();
      int cyc;
      obj_valid = 5'b0;
      log_q.delete();
      run_frame(-1, cyc);
      tests++;
      if (cyc != 13) begin
         fails++;
         $display("FAIL empty_latency: %0d cycles required 13", cyc);
      end
      tests++;
      if (log_q.size() != 0) begin
         fails++;
         $display("FAIL empty_draws: %0d draws required 0", log_q.size());
      end
   endtask

   task automatic test_first_frame();
      int cyc;
      lat = 3;
      obj_valid = 5'b00001;
      set_obj(0, 75, 100, 2);
      log_q.delete();
      run_frame(-1, cyc);
      tests++;
      if (log_q.size() != 1) begin
         fails++;
         $display("FAIL first_count: %0d draws required 1", log_q.size());
      end else begin
         tests++;
         if (log_q[0] !== mk(75, 100, 2)) begin
            fails++;
            $display("FAIL first_rect: got %h required %h", log_q[0], mk(75, 100, 2));
         end
      end
      tests++;
      if (cyc != 17) begin
         fails++;
         $display("FAIL first_latency: %0d cycles required 17", cyc);
      end
      tests++;
      if (o_busy !== 1'b0) begin
         fails++;
         $display("FAIL fdone_busy: busy=%b during frame_done required 0", o_busy);
      end
      @(negedge clk);
      tests++;
      if (o_frame_done !== 1'b0) begin
         fails++;
         $display("FAIL fdone_pulse: frame_done=%b one cycle later required 0", o_frame_done);
      end
   endtask

   task automatic test_move();
      int cyc;
      rect_t exp[2];
      set_obj(0, 85, 100, 2);
      log_q.delete();
      run_frame(-1, cyc);
      exp[0] = mk(75, 100, 0);
      exp[1] = mk(85, 100, 2);
      tests++;
      if (log_q.size() != 2) begin
         fails++;
         $display("FAIL move_count: %0d draws required 2", log_q.size());
      end else begin
         for (int i = 0; i < 2; i++) begin
            tests++;
            if (log_q[i] !== exp[i]) begin
               fails++;
               $display("FAIL move_rect%0d: got %h required %h", i, log_q[i], exp[i]);
            end
         end
      end
   endtask

   task automatic test_all_slots();
      int cyc;
      rect_t exp[10];
      lat = 3;
      obj_valid = 5'b11111;
      for (int k = 0; k < 5; k++) set_obj(k, 10 + 20*k, 5 + 10*k, k + 1);
      log_q.delete();
      run_frame(-1, cyc);
      tests++;
      if (log_q.size() != 6) begin
         fails++;
         $display("FAIL all_first_count: %0d draws required 6", log_q.size());
      end
      for (int k = 0; k < 5; k++) begin
         exp[k]     = mk(10 + 20*k, 5 + 10*k, 0);
         exp[k + 5] = mk(12 + 20*k, 6 + 10*k, 7 - k);
         set_obj(k, 12 + 20*k, 6 + 10*k, 7 - k);
      end
      log_q.delete();
      stab_err = 0;
      run_frame(-1, cyc);
      tests++;
      if (log_q.size() != 10) begin
         fails++;
         $display("FAIL all_count: %0d draws required 10", log_q.size());
      end else begin
         for (int i = 0; i < 10; i++) begin
            tests++;
            if (log_q[i] !== exp[i]) begin
               fails++;
               $display("FAIL all_rect%0d: got %h required %h", i, log_q[i], exp[i]);
            end
         end
      end
      tests++;
      if (stab_err != 0) begin
         fails++;
         $display("FAIL all_stable: %0d output changes while waiting for done, required 0", stab_err);
      end
   endtask

   task automatic test_overrun();
      int cyc;
      int busy_seen;
      rect_t exp[10];
      lat = 1;
      for (int k = 0; k < 5; k++) begin
         exp[k]     = mk(12 + 20*k, 6 + 10*k, 0);
         exp[k + 5] = mk(12 + 20*k, 6 + 10*k, 7 - k);
      end
      log_q.delete();
      run_frame(3, cyc);
      tests++;
      if (o_overrun !== 1'b1) begin
         fails++;
         $display("FAIL ovr_set: overrun=%b required 1", o_overrun);
      end
      tests++;
      if (log_q.size() != 10) begin
         fails++;
         $display("FAIL ovr_count: %0d draws required 10", log_q.size());
      end else begin
         for (int i = 0; i < 10; i++) begin
            tests++;
            if (log_q[i] !== exp[i]) begin
               fails++;
               $display("FAIL ovr_rect%0d: got %h required %h", i, log_q[i], exp[i]);
            end
         end
      end
      busy_seen = 0;
      repeat (20) begin
         @(negedge clk);
         if (o_busy) busy_seen++;
      end
      tests++;
      if (busy_seen != 0) begin
         fails++;
         $display("FAIL ovr_no_queue: busy high %0d cycles after frame, required 0", busy_seen);
      end
      tests++;
      if (o_overrun !== 1'b1) begin
         fails++;
         $display("FAIL ovr_sticky: overrun=%b required 1", o_overrun);
      end
   endtask

   task automatic test_finish_tick();
      int cyc;
      do_reset();
      obj_valid = 5'b0;
      run_frame(-1, cyc);
      i_frame_tick = 1'b1;
      @(negedge clk);
      i_frame_tick = 1'b0;
      tests++;
      if (o_overrun !== 1'b1 || o_busy !== 1'b0) begin
         fails++;
         $display("FAIL fin_tick: overrun=%b busy=%b required 1 0", o_overrun, o_busy);
      end
   endtask

   task automatic test_reset_mid();
      int cyc;
      int waitc;
      do_reset();
      lat = 2;
      obj_valid = 5'b00001;
      set_obj(0, 40, 30, 5);
      @(negedge clk);
      i_frame_tick = 1'b1;
      @(negedge clk);
      i_frame_tick = 1'b0;
      waitc = 0;
      while (!dif.draw && waitc < 100) begin
         @(negedge clk);
         waitc++;
      end
      tests++;
      if (!dif.draw) begin
         fails++;
         $display("FAIL rmid_draw: draw=%b required 1 within 100 cycles", dif.draw);
      end
      @(negedge clk);
      i_reset = 1'b1;
      @(negedge clk);
      tests++;
      if ({dif.draw, o_busy, o_frame_done, o_overrun, dif.start_x, dif.start_y, dif.color} !== 22'd0) begin
         fails++;
         $display("FAIL rmid_outs: draw=%b busy=%b x=%0d y=%0d c=%0d required all 0",
                  dif.draw, o_busy, dif.start_x, dif.start_y, dif.color);
      end
      i_reset = 1'b0;
      repeat (10) @(negedge clk);
      tests++;
      if (log_q.size() != 1 || o_busy !== 1'b0) begin
         fails++;
         $display("FAIL rmid_quiet: %0d draws busy=%b required 1 0", log_q.size(), o_busy);
      end
      log_q.delete();
      run_frame(-1, cyc);
      tests++;
      if (log_q.size() != 1 || log_q[0] !== mk(40, 30, 5)) begin
         fails++;
         $display("FAIL rmid_next: %0d draws first=%h required 1 %h",
                  log_q.size(), (log_q.size() > 0) ? log_q[0] : rect_t'(0), mk(40, 30, 5));
      end
   endtask

   task automatic test_slot2_drop();
      int cyc;
      rect_t exp[3];
      do_reset();
      lat = 1;
      obj_valid = 5'b00101;
      set_obj(0, 20, 10, 1);
      set_obj(2, 60, 50, 4);
      run_frame(-1, cyc);
      obj_valid = 5'b00001;
      log_q.delete();
      run_frame(-1, cyc);
      exp[0] = mk(20, 10, 0);
      exp[1] = mk(60, 50, 0);
      exp[2] = mk(20, 10, 1);
      tests++;
      if (log_q.size() != 3) begin
         fails++;
         $display("FAIL drop_count: %0d draws required 3", log_q.size());
      end else begin
         for (int i = 0; i < 3; i++) begin
            tests++;
            if (log_q[i] !== exp[i]) begin
               fails++;
               $display("FAIL drop_rect%0d: got %h required %h", i, log_q[i], exp[i]);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_empty_frame();
      test_first_frame();
      test_move();
      test_all_slots();
      test_overrun();
      test_finish_tick();
      test_reset_mid();
      test_slot2_drop();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
